// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with per-register pending (scoreboard) tracking
module scoreboard_regfile #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [XLEN-1:0]     wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [XLEN-1:0]     wr1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [AW:0]         busy_count
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;
   logic             wr0_ok;
   logic             wr1_ok;
   logic             iss_ok;

   // An address is live when it exists and is not the hardwired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW+1)'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign wr0_ok = wr0_en && addr_ok(wr0_addr);
   assign wr1_ok = wr1_en && addr_ok(wr1_addr);
   assign iss_ok = iss_en && addr_ok(iss_addr);

   // Read ports: dead addresses read 0; live ones forward wr1, then wr0, then storage.
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] a;
      logic          a_ok;
      logic          hit0;
      logic          hit1;
      assign a    = rd_addr[g*AW +: AW];
      assign a_ok = addr_ok(a);
      assign hit0 = wr0_ok && (wr0_addr == a);
      assign hit1 = wr1_ok && (wr1_addr == a);
      assign rd_data[g*XLEN +: XLEN] = !a_ok ? '0 :
                                       hit1  ? wr1_data :
                                       hit0  ? wr0_data : regs[a];
      assign rd_busy[g] = a_ok && busy[a] && !hit0 && !hit1;
   end

   // Next pending vector: writebacks clear, issue sets afterwards so it wins; flush clears all.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
         if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
         if (iss_ok) busy_nxt[iss_addr] = 1'b1;
      end
      for (int i = 0; i < NREGS; i++) begin
         cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
      end
   end

   // State update: reset clears everything; wr1 is applied last so it wins on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         busy       <= '0;
         busy_count <= '0;
      end else begin
         if (wr0_ok) regs[wr0_addr] <= wr0_data;
         if (wr1_ok) regs[wr1_addr] <= wr1_data;
         busy       <= busy_nxt;
         busy_count <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - randomized model-checked bench for scoreboard_regfile
module tb_scoreboard_regfile;

   localparam int NR = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ra0, ra1;
   logic [63:0] rdd;
   logic [1:0]  rdb;
   logic        wr0_en, wr1_en, iss_en, flush;
   logic [4:0]  wr0_addr, wr1_addr, iss_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [5:0]  cnt;

   logic        s_rst, s_wr0_en, s_iss_en;
   logic [4:0]  s_ra0, s_ra1, s_wr0_addr, s_iss_addr;
   logic [31:0] s_wr0_data;
   logic [63:0] s_rdd;
   logic [1:0]  s_rdb;
   logic [5:0]  s_cnt;

   logic [31:0] m_regs [NR];
   bit          m_busy [NR];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   scoreboard_regfile u_dut (
      .clk(clk), .rst(rst), .rd_addr({ra1, ra0}), .rd_data(rdd), .rd_busy(rdb),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_count(cnt)
   );

   scoreboard_regfile #(.NREGS(24)) u_small (
      .clk(clk), .rst(s_rst), .rd_addr({s_ra1, s_ra0}), .rd_data(s_rdd), .rd_busy(s_rdb),
      .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
      .wr1_en(1'b0), .wr1_addr(5'd0), .wr1_data(32'd0),
      .iss_en(s_iss_en), .iss_addr(s_iss_addr), .flush(1'b0), .busy_count(s_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ok(input logic [4:0] a);
      return (int'(a) < NR) && (a != 5'd0);
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (!m_ok(a)) return 32'd0;
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!m_ok(a)) return 1'b0;
      if ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic m_update();
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (wr0_en && m_ok(wr0_addr)) m_regs[wr0_addr] = wr0_data;
         if (wr1_en && m_ok(wr1_addr)) m_regs[wr1_addr] = wr1_data;
         if (flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
         end else begin
            if (wr0_en && m_ok(wr0_addr)) m_busy[wr0_addr] = 1'b0;
            if (wr1_en && m_ok(wr1_addr)) m_busy[wr1_addr] = 1'b0;
            if (iss_en && m_ok(iss_addr)) m_busy[iss_addr] = 1'b1;
         end
      end
   endtask

   // One cycle: compare read ports against the model, clock, advance model, compare count.
   task automatic tick();
      #2;
      chk("rd_data0", {32'd0, rdd[31:0]},  {32'd0, exp_data(ra0)});
      chk("rd_data1", {32'd0, rdd[63:32]}, {32'd0, exp_data(ra1)});
      chk("rd_busy",  {62'd0, rdb},        {62'd0, exp_busy(ra1), exp_busy(ra0)});
      @(posedge clk);
      m_update();
      #1;
      chk("busy_count", {58'd0, cnt}, 64'(m_count()));
   endtask

   task automatic idle();
      rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
      wr0_addr = '0; wr1_addr = '0; iss_addr = '0; wr0_data = '0; wr1_data = '0;
      ra0 = '0; ra1 = '0;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = 32'hx;
         m_busy[i] = 1'b0;
      end
      idle();
      s_rst = 1'b1; s_wr0_en = 1'b0; s_iss_en = 1'b0;
      s_ra0 = '0; s_ra1 = '0; s_wr0_addr = '0; s_iss_addr = '0; s_wr0_data = '0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      idle();
      s_rst = 1'b0;

      // Post-reset: every address reads 0, not busy.
      for (int a = 0; a < NR; a += 2) begin
         ra0 = 5'(a); ra1 = 5'(a + 1);
         #1;
         chk("reset_rd", rdd, 64'd0);
         chk("reset_busy", {62'd0, rdb}, 64'd0);
      end
      chk("reset_count", {58'd0, cnt}, 64'd0);

      // x5 write with same-cycle bypass, then stored value.
      idle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; ra0 = 5'd5;
      #1 chk("bypass_x5", {32'd0, rdd[31:0]}, 64'hDEADBEEF);
      tick();
      idle(); ra0 = 5'd5;
      #1 chk("stored_x5", {32'd0, rdd[31:0]}, 64'hDEADBEEF);
      tick();

      // Both ports hit x7: wr1 wins.
      idle(); wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
      wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22; ra1 = 5'd7;
      #1 chk("fwd_wr1_wins", {32'd0, rdd[63:32]}, 64'h22);
      tick();
      idle(); ra0 = 5'd7;
      #1 chk("stored_wr1_wins", {32'd0, rdd[31:0]}, 64'h22);
      tick();

      // x0 is hardwired.
      idle(); wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 5'd0;
      #1 chk("x0_fwd", {32'd0, rdd[31:0]}, 64'd0);
      chk("x0_busy", {63'd0, rdb[0]}, 64'd0);
      tick();
      chk("x0_count", {58'd0, cnt}, 64'd0);
      idle();
      #1 chk("x0_stored", {32'd0, rdd[31:0]}, 64'd0);

      // Issue / writeback on x3.
      idle(); iss_en = 1'b1; iss_addr = 5'd3; ra0 = 5'd3;
      tick();
      chk("iss3_count", {58'd0, cnt}, 64'd1);
      idle(); ra0 = 5'd3;
      #1 chk("iss3_busy", {63'd0, rdb[0]}, 64'd1);
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
      #1 chk("wb3_busy_same_cycle", {63'd0, rdb[0]}, 64'd0);
      tick();
      chk("wb3_count", {58'd0, cnt}, 64'd0);
      idle(); iss_en = 1'b1; iss_addr = 5'd3; wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h34;
      tick();
      chk("iss_wb3_count", {58'd0, cnt}, 64'd1);
      idle(); ra0 = 5'd3;
      #1 chk("iss_wb3_busy", {63'd0, rdb[0]}, 64'd1);
      wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h35;
      tick();

      // Issue three, then flush with a competing issue.
      foreach (ra0[i]) begin end
      idle(); iss_en = 1'b1; iss_addr = 5'd1; tick();
      iss_addr = 5'd2; tick();
      iss_addr = 5'd4; tick();
      chk("three_issued", {58'd0, cnt}, 64'd3);
      idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      chk("flush_count", {58'd0, cnt}, 64'd0);
      idle(); ra0 = 5'd9; ra1 = 5'd5;
      #1 chk("flush_x9_busy", {63'd0, rdb[0]}, 64'd0);
      chk("flush_data_kept", {32'd0, rdd[63:32]}, 64'hDEADBEEF);
      tick();

      // Reset mid-operation, with a write and issue in the reset cycle.
      idle(); wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h55; tick();
      idle(); iss_en = 1'b1; iss_addr = 5'd11; tick();
      idle(); rst = 1'b1; wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h99;
      iss_en = 1'b1; iss_addr = 5'd12; tick();
      idle(); ra0 = 5'd10; ra1 = 5'd12;
      #1 chk("rst_x10", {32'd0, rdd[31:0]}, 64'd0);
      chk("rst_x12", {32'd0, rdd[63:32]}, 64'd0);
      chk("rst_busy", {62'd0, rdb}, 64'd0);
      chk("rst_count", {58'd0, cnt}, 64'd0);

      // NREGS=24 instance: addresses 24..31 are dead, 23 is live.
      s_wr0_en = 1'b1; s_wr0_addr = 5'd30; s_wr0_data = 32'hAB; s_ra0 = 5'd30;
      s_iss_en = 1'b1; s_iss_addr = 5'd30;
      #1 chk("small_oor_fwd", {32'd0, s_rdd[31:0]}, 64'd0);
      @(posedge clk); #1;
      s_wr0_addr = 5'd23; s_wr0_data = 32'h77; s_iss_en = 1'b0; s_ra1 = 5'd23;
      #1 chk("small_oor_read", {32'd0, s_rdd[31:0]}, 64'd0);
      chk("small_oor_count", {58'd0, s_cnt}, 64'd0);
      chk("small_x23_fwd", {32'd0, s_rdd[63:32]}, 64'h77);
      @(posedge clk); #1;
      s_wr0_en = 1'b0;
      #1 chk("small_x23_stored", {32'd0, s_rdd[63:32]}, 64'h77);
      chk("small_oor_busy", {62'd0, s_rdb}, 64'd0);

      // Randomized traffic on a narrow address window to force collisions.
      for (int c = 0; c < 600; c++) begin
         idle();
         rst      = ($urandom_range(0, 99) < 2);
         flush    = ($urandom_range(0, 99) < 5);
         wr0_en   = $urandom_range(0, 1);
         wr1_en   = $urandom_range(0, 1);
         iss_en   = ($urandom_range(0, 9) < 4);
         wr0_addr = 5'($urandom_range(0, 7));
         wr1_addr = 5'($urandom_range(0, 7));
         iss_addr = 5'($urandom_range(0, 7));
         wr0_data = $urandom;
         wr1_data = $urandom;
         case ($urandom_range(0, 3))
            0: ra0 = wr0_addr;
            1: ra0 = wr1_addr;
            2: ra0 = iss_addr;
            default: ra0 = 5'($urandom_range(0, 31));
         endcase
         ra1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers (≥2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (≥1).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port rd_addr  input  NRD*AW  packed read addresses; port i in bits [i*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRD*XLEN  packed read data, port i in [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRD  per-read-port pending flag.
REQ-010 SHALL have ports wr0_en/wr1_en  input  1 each  write enables.
REQ-011 SHALL have ports wr0_addr/wr1_addr  input  AW each, and wr0_data/wr1_data  input  XLEN each.
REQ-012 SHALL have port iss_en  input  1  issue: mark iss_addr as pending.
REQ-013 SHALL have port iss_addr  input  AW  destination register being issued.
REQ-014 SHALL have port flush  input  1  clear all pending flags.
REQ-015 SHALL have port busy_count  output  AW+1  registered count of pending registers.

Function
REQ-016 SHALL hold NREGS x XLEN data registers and an NREGS-bit busy vector.
REQ-017 SHALL produce rd_data/rd_busy combinationally (zero-cycle read latency).
REQ-018 SHALL write wrN_data to wrN_addr at posedge when wrN_en=1.
REQ-019 SHALL, when both write ports target the same address in one cycle, store wr1_data (wr1 wins).
REQ-020 SHALL forward same-cycle writes to reads: matching enabled wr1 first, else matching wr0, else stored value.
REQ-021 SHALL, when ZERO_REG=1, return 0 and rd_busy=0 for address 0, ignore writes and issues to address 0, and never forward to address 0.
REQ-022 SHALL treat addresses ≥ NREGS as out of range: read 0, rd_busy 0, writes and issues ignored.
REQ-023 SHALL set busy[iss_addr] at posedge when iss_en=1.
REQ-024 SHALL clear busy[a] at posedge when an enabled write port targets a.
REQ-025 SHALL, on same-cycle issue and writeback to the same address, leave busy set (issue wins: new producer).
REQ-026 SHALL drive rd_busy[i] = busy[rd_addr_i] AND NOT (same-cycle enabled write to rd_addr_i).
REQ-027 SHALL, on flush=1, clear all busy bits at posedge; flush overrides same-cycle iss_en; data writes in that cycle still occur.
REQ-028 SHALL update busy_count at posedge to popcount of the next busy vector (registered, equals popcount of busy at all times).
REQ-029 SHALL never modify data registers on issue or flush.

Reset
REQ-030 SHALL, when rst=1 at posedge, clear all data registers, all busy bits, and busy_count to 0; rst overrides writes, issue and flush.
REQ-031 SHALL, after reset, read 0 with rd_busy=0 on every port for every address until written or issued.
REQ-032 SHALL discard any in-flight issue/write presented in a reset cycle (reset mid-operation leaves no partial state).

Verification
REQ-033 SHALL be verified: write x5=0xDEADBEEF via wr0, next cycle read port 0 addr 5 -> 0xDEADBEEF; same-cycle read during write -> 0xDEADBEEF (bypass).
REQ-034 SHALL be verified: wr0 x7=0x11, wr1 x7=0x22 same cycle -> forwarded and stored value 0x22.
REQ-035 SHALL be verified: write x0=0xFFFFFFFF and iss x0 -> read x0 = 0, rd_busy=0, busy_count=0.
REQ-036 SHALL be verified: iss x3 -> rd_busy=1, busy_count=1; wr x3 next cycle -> rd_busy=0 that cycle, busy_count=0 after; iss+wr x3 same cycle -> busy remains 1.
REQ-037 SHALL be verified: issue x1,x2,x4 -> busy_count=3; flush with iss x9 -> busy_count=0, x9 not busy, register data unchanged.
REQ-038 SHALL be verified: write x10=0x55, iss x11, then rst=1 one cycle -> x10 reads 0, busy_count=0; also NREGS=24 instance: address 30 reads 0, write ignored.
